// File: rtl/gray_stream_decoder_pkg.sv
// Shared definitions for the gray stream decoder slice.
// Holds the state encoding, direction codes and the error saturation limit.
package gray_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_e;

    localparam logic       DIR_UP  = 1'b0;
    localparam logic       DIR_DN  = 1'b1;
    localparam logic [7:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Stream bus between the gray pattern source and the decoder.
// master: drives vld/dir/g/clr, receives status; slave: the decoder.
interface gray_stream_if #(
    parameter int W = 8
);
    logic         vld;
    logic         dir;
    logic [W-1:0] g;
    logic         clr;
    logic [W-1:0] bin;
    logic         bin_vld;
    logic         locked;
    logic         err;
    logic [7:0]   err_cnt;

    modport master (
        output vld, dir, g, clr,
        input  bin, bin_vld, locked, err, err_cnt
    );

    modport slave (
        input  vld, dir, g, clr,
        output bin, bin_vld, locked, err, err_cnt
    );
endinterface

// File: rtl/gray_stream_decoder_gray2bin.sv
// Combinational gray-to-binary converter.
// Ports: g_i gray word in, b_o binary word out.
module gray2bin #(
    parameter int W = 8
) (
    input  logic [W-1:0] g_i,
    output logic [W-1:0] b_o
);
    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        b_o = '0;
        for (int i = 0; i < W; i++) begin
            b_o[i] = ^(g_i >> i);
        end
    end
endmodule

// File: rtl/gray_stream_decoder.sv
// Decodes a gray-count stream, tracks up/down continuity and lock.
// Ports: clk, rs (async active-high reset), s (gray_stream_if slave).
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int W        = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rs,
    gray_stream_if.slave  s
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

    state_e       state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic [3:0]   match_q, match_d;
    logic [W-1:0] bin_q, bin_d;
    logic         bin_vld_q, bin_vld_d;
    logic         locked_q, locked_d;
    logic         err_q, err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    logic [W-1:0] b;
    logic [W-1:0] expd;
    logic         hit;

    gray2bin #(.W(W)) u_g2b (
        .g_i (s.g),
        .b_o (b)
    );

    // Expected word follows the direction sampled with this word.
    assign expd = (s.dir == DIR_DN) ? prev_q - 1'b1
                                    : prev_q + 1'b1;
    assign hit  = (b == expd);

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            match_q   <= '0;
            bin_q     <= '0;
            bin_vld_q <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            bin_q     <= bin_d;
            bin_vld_q <= bin_vld_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        match_d   = match_q;
        bin_d     = bin_q;
        bin_vld_d = 1'b0;
        locked_d  = locked_q;
        err_d     = 1'b0;
        if (s.vld) begin
            bin_d     = b;
            bin_vld_d = 1'b1;
            prev_d    = b;
            unique case (state_q)
                HUNT: begin
                    match_d = 4'd1;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (hit) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LOCK_N) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        // Out-of-sequence word restarts the count.
                        match_d = 4'd1;
                    end
                end
                LOCK: begin
                    if (!hit) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        match_d  = 4'd1;
                        state_d  = SYNC;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // Clear beats a simultaneous error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s.clr) begin
            err_cnt_d = '0;
        end else if (err_d && err_cnt_q != ERR_SAT) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign s.bin     = bin_q;
    assign s.bin_vld = bin_vld_q;
    assign s.locked  = locked_q;
    assign s.err     = err_q;
    assign s.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder.
// Vector table plus hand sequences for saturation and async reset.
module tb_gray_stream_decoder;
    logic clk;
    logic rs;
    int   n_tests;
    int   n_fail;

    gray_stream_if #(.W(8)) bus ();

    gray_stream_decoder #(.W(8), .LOCK_CNT(4)) dut (
        .clk (clk),
        .rs  (rs),
        .s   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       dir;
        logic [7:0] g;
        logic       clr;
        logic [7:0] bin;
        logic       bvld;
        logic       lk;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", nm, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] bin,
                           input logic bvld, input logic lk,
                           input logic err, input logic [7:0] cnt);
        chk({tag, ".bin"}, bus.bin, bin);
        chk({tag, ".bin_vld"}, 8'(bus.bin_vld), 8'(bvld));
        chk({tag, ".locked"}, 8'(bus.locked), 8'(lk));
        chk({tag, ".err"}, 8'(bus.err), 8'(err));
        chk({tag, ".err_cnt"}, bus.err_cnt, cnt);
    endtask

    task automatic drive(input logic v, input logic d,
                         input logic [7:0] gw, input logic c);
        bus.vld = v;
        bus.dir = d;
        bus.g   = gw;
        bus.clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic v, input logic d, input logic [7:0] gw,
                        input logic c, input logic [7:0] b,
                        input logic bv, input logic lk, input logic e,
                        input logic [7:0] n);
        vec_t x;
        x.vld = v; x.dir = d; x.g = gw; x.clr = c;
        x.bin = b; x.bvld = bv; x.lk = lk; x.err = e; x.cnt = n;
        vecs.push_back(x);
    endtask

    logic [7:0] cur;
    logic [7:0] ecnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.vld = 1'b0;
        bus.dir = 1'b0;
        bus.g   = 8'h00;
        bus.clr = 1'b0;

        //   vld dir g     clr bin   bv lk er cnt
        addv(1, 0, 8'h00, 0, 8'd0,   1, 0, 0, 0);
        addv(1, 0, 8'h01, 0, 8'd1,   1, 0, 0, 0);
        addv(1, 0, 8'h03, 0, 8'd2,   1, 0, 0, 0);
        addv(1, 0, 8'h02, 0, 8'd3,   1, 1, 0, 0);
        addv(1, 0, 8'h06, 0, 8'd4,   1, 1, 0, 0);
        addv(0, 0, 8'h55, 0, 8'd4,   0, 1, 0, 0);
        addv(0, 1, 8'hAA, 0, 8'd4,   0, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 8'd4,   0, 1, 0, 0);
        addv(1, 1, 8'h02, 0, 8'd3,   1, 1, 0, 0);
        addv(1, 0, 8'h05, 0, 8'd6,   1, 0, 1, 1);
        addv(1, 0, 8'h04, 0, 8'd7,   1, 0, 0, 1);
        addv(1, 0, 8'h0C, 0, 8'd8,   1, 0, 0, 1);
        addv(1, 0, 8'h0D, 0, 8'd9,   1, 1, 0, 1);
        addv(1, 0, 8'h82, 1, 8'd252, 1, 0, 1, 0);
        addv(1, 0, 8'h83, 0, 8'd253, 1, 0, 0, 0);
        addv(1, 0, 8'h81, 0, 8'd254, 1, 0, 0, 0);
        addv(1, 0, 8'h80, 0, 8'd255, 1, 1, 0, 0);
        addv(1, 0, 8'h00, 0, 8'd0,   1, 1, 0, 0);
        addv(1, 0, 8'h01, 0, 8'd1,   1, 1, 0, 0);
        addv(1, 1, 8'h00, 0, 8'd0,   1, 1, 0, 0);
        addv(1, 1, 8'h80, 0, 8'd255, 1, 1, 0, 0);
        addv(1, 1, 8'h81, 0, 8'd254, 1, 1, 0, 0);

        rs = 1'b1;
        #12;
        chk_all("reset", 8'd0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rs = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].dir, vecs[i].g, vecs[i].clr);
            chk_all($sformatf("v%0d", i), vecs[i].bin, vecs[i].bvld,
                    vecs[i].lk, vecs[i].err, vecs[i].cnt);
        end

        // Saturation: 300 breaks, each followed by a 3-word relock.
        cur  = 8'd254;
        ecnt = 8'd0;
        for (int k = 0; k < 300; k++) begin
            cur = cur + 8'd5;
            drive(1, 0, to_gray(cur), 0);
            if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
            chk($sformatf("sat%0d.err", k), 8'(bus.err), 8'd1);
            chk($sformatf("sat%0d.cnt", k), bus.err_cnt, ecnt);
            for (int j = 0; j < 3; j++) begin
                cur = cur + 8'd1;
                drive(1, 0, to_gray(cur), 0);
            end
            if (k == 299) begin
                chk("sat.locked", 8'(bus.locked), 8'd1);
            end
        end
        chk("sat.final", bus.err_cnt, 8'hFF);

        // Plain clear with no error pending.
        drive(0, 0, 8'h00, 1);
        chk_all("clr", cur, 0, 1, 0, 8'd0);

        // Async reset between edges while locked.
        drive(1, 0, to_gray(cur + 8'd1), 0);
        chk("pre_rs.locked", 8'(bus.locked), 8'd1);
        #2;
        rs = 1'b1;
        #1;
        chk_all("async_rs", 8'd0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rs = 1'b0;
        #1;
        drive(1, 0, 8'h07, 0);
        chk_all("post_rs", 8'd5, 1, 0, 0, 8'd0);
        drive(1, 0, 8'h05, 0);
        chk_all("post_rs2", 8'd6, 1, 0, 0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
